atm_pin_controller: RTL and testbench



---
 rtl/atm_pin_controller_if.sv | 36 +++
 rtl/atm_pin_controller.sv | 150 +++++++++++++++
 tb/tb_atm_pin_controller.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/atm_pin_controller_if.sv
// rtl/atm_pin_controller_if.sv - keypad, card and latch-bank signals of the PIN controller
interface atm_pin_controller_if #(
    parameter int DIGITS    = 4,
    parameter int DIGIT_W   = 4,
    parameter int MAX_TRIES = 3
);
    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    logic                        card_in;
    logic                        key_valid;
    logic [3:0]                  key_code;
    logic [DIGITS*DIGIT_W-1:0]   stored_pin;
    logic [DIGITS*DIGIT_W-1:0]   entered_pin;
    logic [DIGITS-1:0]           latch_en;
    logic [DIGIT_W-1:0]          latch_data;
    logic                        latch_rst;
    logic [CNT_W-1:0]            digit_count;
    logic [TRY_W-1:0]            tries_left;
    logic                        access_granted;
    logic                        pin_error;
    logic                        timeout_eject;
    logic                        locked;

    modport master (
        input  card_in, key_valid, key_code, stored_pin, entered_pin,
        output latch_en, latch_data, latch_rst, digit_count, tries_left,
               access_granted, pin_error, timeout_eject, locked
    );

    modport slave (
        output card_in, key_valid, key_code, stored_pin, entered_pin,
        input  latch_en, latch_data, latch_rst, digit_count, tries_left,
               access_granted, pin_error, timeout_eject, locked
    );
endinterface

// File: rtl/atm_pin_controller.sv
// rtl/atm_pin_controller.sv - PIN entry sequencer driving an external per-digit latch bank
module atm_pin_controller #(
    parameter int DIGITS    = 4,
    parameter int DIGIT_W   = 4,
    parameter int MAX_TRIES = 3,
    parameter int TIMEOUT   = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    atm_pin_controller_if.master  bus
);
    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, ENTRY, COMPARE, GRANTED, DENIED, LOCKED
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     digit_count, dc_nxt;
    logic [TRY_W-1:0]     tries_left, tries_nxt;
    logic [TMR_W-1:0]     timer, timer_nxt;
    logic [DIGITS-1:0]    latch_en, en_nxt;
    logic [DIGIT_W-1:0]   latch_data, data_nxt;
    logic                 latch_rst, latch_rst_nxt;
    logic                 clr_pulse;
    logic                 pin_error, err_nxt;
    logic                 timeout_eject, timeout_nxt;
    logic                 access_granted, locked;

    always_comb begin
        state_nxt   = state;
        dc_nxt      = digit_count;
        tries_nxt   = tries_left;
        timer_nxt   = timer;
        en_nxt      = '0;
        data_nxt    = latch_data;
        clr_pulse   = 1'b0;
        err_nxt     = 1'b0;
        timeout_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (bus.card_in) begin
                    state_nxt = ENTRY;
                    tries_nxt = TRY_W'(MAX_TRIES);
                    timer_nxt = '0;
                end
            end
            ENTRY: begin
                // Card removal outranks any key or timer event this cycle
                if (!bus.card_in) begin
                    state_nxt = IDLE;
                end else if (bus.key_valid) begin
                    timer_nxt = '0;
                    if (bus.key_code <= 4'd9) begin
                        if (digit_count < CNT_W'(DIGITS)) begin
                            en_nxt   = DIGITS'(1) << digit_count;
                            data_nxt = DIGIT_W'(bus.key_code);
                            dc_nxt   = digit_count + CNT_W'(1);
                        end
                    end else if (bus.key_code == 4'hA) begin
                        clr_pulse = 1'b1;
                        dc_nxt    = '0;
                    end else if (bus.key_code == 4'hB && digit_count == CNT_W'(DIGITS)) begin
                        state_nxt = COMPARE;
                    end
                end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            COMPARE: begin
                if (!bus.card_in) begin
                    state_nxt = IDLE;
                end else if (bus.entered_pin == bus.stored_pin) begin
                    state_nxt = GRANTED;
                end else begin
                    tries_nxt = tries_left - TRY_W'(1);
                    if (tries_left == TRY_W'(1)) begin
                        state_nxt = LOCKED;
                    end else begin
                        state_nxt = DENIED;
                        err_nxt   = 1'b1;
                        clr_pulse = 1'b1;
                        dc_nxt    = '0;
                    end
                end
            end
            GRANTED: begin
                if (!bus.card_in) state_nxt = IDLE;
            end
            DENIED: begin
                if (!bus.card_in) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = ENTRY;
                    timer_nxt = '0;
                end
            end
            LOCKED: state_nxt = LOCKED;
            default: state_nxt = IDLE;
        endcase

        // Outputs are registered, so IDLE's held latch reset is launched on the edge into IDLE
        if (state_nxt == IDLE) dc_nxt = '0;
        latch_rst_nxt = clr_pulse || (state_nxt == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            digit_count    <= '0;
            tries_left     <= TRY_W'(MAX_TRIES);
            timer          <= '0;
            latch_en       <= '0;
            latch_data     <= '0;
            latch_rst      <= 1'b1;
            pin_error      <= 1'b0;
            timeout_eject  <= 1'b0;
            access_granted <= 1'b0;
            locked         <= 1'b0;
        end else begin
            state          <= state_nxt;
            digit_count    <= dc_nxt;
            tries_left     <= tries_nxt;
            timer          <= timer_nxt;
            latch_en       <= en_nxt;
            latch_data     <= data_nxt;
            latch_rst      <= latch_rst_nxt;
            pin_error      <= err_nxt;
            timeout_eject  <= timeout_nxt;
            access_granted <= (state_nxt == GRANTED);
            locked         <= (state_nxt == LOCKED);
        end
    end

    assign bus.latch_en       = latch_en;
    assign bus.latch_data     = latch_data;
    assign bus.latch_rst      = latch_rst;
    assign bus.digit_count    = digit_count;
    assign bus.tries_left     = tries_left;
    assign bus.access_granted = access_granted;
    assign bus.pin_error      = pin_error;
    assign bus.timeout_eject  = timeout_eject;
    assign bus.locked         = locked;
endmodule

// File: tb/tb_atm_pin_controller.sv
// tb/tb_atm_pin_controller.sv - directed self-checking bench for atm_pin_controller
module tb_atm_pin_controller;
    localparam int DIGITS    = 4;
    localparam int DIGIT_W   = 4;
    localparam int MAX_TRIES = 3;
    localparam int TIMEOUT   = 255;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   errors = 0;
    logic [DIGITS*DIGIT_W-1:0] bank = '0;

    atm_pin_controller_if #(.DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .MAX_TRIES(MAX_TRIES)) bus ();

    atm_pin_controller #(
        .DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .MAX_TRIES(MAX_TRIES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // External D-latch bank, resolved mid-cycle while its enable pulse is high
    always @(negedge clk) begin
        if (bus.latch_rst) bank <= '0;
        else for (int i = 0; i < DIGITS; i++)
            if (bus.latch_en[i]) bank[i*DIGIT_W +: DIGIT_W] <= bus.latch_data;
    end
    assign bus.entered_pin = bank;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        bus.key_valid = 1'b1;
        bus.key_code  = k;
        tick();
        bus.key_valid = 1'b0;
    endtask

    task automatic enter_digits(input logic [3:0] a, b, c, d);
        press(a); press(b); press(c); press(d);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.card_in = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_code = 4'h0;
        bus.stored_pin = 16'h4321;
        tick(); tick();
        check("rst_latch_rst", bus.latch_rst, 1);
        check("rst_latch_en", bus.latch_en, 0);
        check("rst_latch_data", bus.latch_data, 0);
        check("rst_digit_count", bus.digit_count, 0);
        check("rst_tries", bus.tries_left, 3);
        check("rst_flags", {bus.access_granted, bus.pin_error, bus.timeout_eject, bus.locked}, 0);
        rst_n = 1'b1;
        tick();

        // Correct PIN, back-to-back keys
        bus.card_in = 1'b1;
        tick();
        check("entry_latch_rst", bus.latch_rst, 0);
        press(4'd1); check("en_d0", bus.latch_en, 4'b0001); check("data_d0", bus.latch_data, 1);
        press(4'd2); check("en_d1", bus.latch_en, 4'b0010); check("data_d1", bus.latch_data, 2);
        press(4'd3); check("en_d2", bus.latch_en, 4'b0100);
        press(4'd4); check("en_d3", bus.latch_en, 4'b1000); check("dc_4", bus.digit_count, 4);
        press(4'hB);
        check("cmp_not_yet", bus.access_granted, 0);
        check("en_after_enter", bus.latch_en, 0);
        tick();
        check("granted", bus.access_granted, 1);
        press(4'd7);
        check("granted_key_ignored", bus.latch_en, 0);
        bus.card_in = 1'b0;
        tick();
        check("granted_drop", bus.access_granted, 0);
        check("idle_latch_rst", bus.latch_rst, 1);
        tick();

        // Clear mid-entry
        bus.card_in = 1'b1;
        tick();
        press(4'd5); press(4'd6);
        check("clr_dc2", bus.digit_count, 2);
        press(4'hA);
        check("clr_pulse", bus.latch_rst, 1);
        check("clr_dc0", bus.digit_count, 0);
        press(4'd1);
        check("clr_pulse_end", bus.latch_rst, 0);
        press(4'd2); press(4'd3); press(4'd4);
        check("clr_dc4", bus.digit_count, 4);
        press(4'hB); tick();
        check("clr_granted", bus.access_granted, 1);
        bus.card_in = 1'b0;
        tick(); tick();

        // Enter with 3 digits ignored, fifth digit ignored
        bus.card_in = 1'b1;
        tick();
        press(4'd1); press(4'd2); press(4'd3);
        press(4'hB);
        check("short_enter_dc", bus.digit_count, 3);
        tick();
        check("short_enter_nogrant", {bus.access_granted, bus.pin_error}, 0);
        press(4'd4);
        press(4'd9);
        check("fifth_no_en", bus.latch_en, 0);
        check("fifth_dc", bus.digit_count, 4);
        press(4'hB); tick();
        check("fifth_granted", bus.access_granted, 1);
        bus.card_in = 1'b0;
        tick(); tick();

        // Wrong PIN until lockout
        bus.card_in = 1'b1;
        tick();
        check("tries_reload", bus.tries_left, 3);
        enter_digits(4'd0, 4'd0, 4'd0, 4'd0);
        press(4'hB); tick();
        check("err1", bus.pin_error, 1);
        check("err1_tries", bus.tries_left, 2);
        check("err1_latch_rst", bus.latch_rst, 1);
        tick();
        check("err1_pulse_end", bus.pin_error, 0);
        check("err1_dc", bus.digit_count, 0);
        enter_digits(4'd0, 4'd0, 4'd0, 4'd0);
        press(4'hB); tick();
        check("err2", bus.pin_error, 1);
        check("err2_tries", bus.tries_left, 1);
        tick();
        enter_digits(4'd0, 4'd0, 4'd0, 4'd0);
        press(4'hB); tick();
        check("lock", bus.locked, 1);
        check("lock_tries", bus.tries_left, 0);
        check("lock_no_err", bus.pin_error, 0);
        bus.card_in = 1'b0;
        tick(); tick();
        press(4'd1);
        check("lock_hold", bus.locked, 1);
        check("lock_no_en", bus.latch_en, 0);
        rst_n = 1'b0;
        #1;
        check("async_rst_lock", bus.locked, 0);
        check("async_rst_latch_rst", bus.latch_rst, 1);
        check("async_rst_tries", bus.tries_left, 3);
        tick();
        rst_n = 1'b1;
        tick();

        // Card pulled with a simultaneous enter
        bus.card_in = 1'b1;
        tick();
        enter_digits(4'd0, 4'd0, 4'd0, 4'd0);
        bus.key_valid = 1'b1;
        bus.key_code = 4'hB;
        bus.card_in = 1'b0;
        tick();
        bus.key_valid = 1'b0;
        check("pull_idle", bus.latch_rst, 1);
        tick();
        check("pull_no_err", bus.pin_error, 0);
        check("pull_tries", bus.tries_left, 3);

        // Entry timeout, and timer restart by an ignored key
        bus.card_in = 1'b1;
        tick();
        repeat (TIMEOUT - 1) tick();
        check("tmo_early", bus.timeout_eject, 0);
        tick();
        check("tmo_pulse", bus.timeout_eject, 1);
        check("tmo_latch_rst", bus.latch_rst, 1);
        tick();
        check("tmo_pulse_end", bus.timeout_eject, 0);
        repeat (200) tick();
        press(4'hC);
        repeat (200) tick();
        check("tmo_restart", bus.timeout_eject, 0);
        repeat (TIMEOUT - 201) tick();
        check("tmo2_early", bus.timeout_eject, 0);
        tick();
        check("tmo2_pulse", bus.timeout_eject, 1);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
